// File: rtl/tc_register_file_pkg.sv
// tc_register_file_pkg: shared helpers and types for the TC register file.
// Rev 1.0
`default_nettype none

package tc_register_file_pkg;

  // Address width for a given depth; never narrower than one bit.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) w++;
    return w;
  endfunction

  typedef enum logic [1:0] {
    RD_ZERO   = 2'd0,
    RD_MEM    = 2'd1,
    RD_BYPASS = 2'd2
  } rd_src_e;

endpackage

`default_nettype wire

// File: rtl/tc_register_file_rdport.sv
// tc_register_file_rdport: one gated read port with address decode and optional write bypass.
// Rev 1.0
`default_nettype none

module tc_register_file_rdport
  import tc_register_file_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 0
) (
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           load,
  input  logic [ADDR_W-1:0]              raddr,
  input  logic [NUM_WRITE-1:0]           save,
  input  logic [NUM_WRITE*ADDR_W-1:0]    waddr,
  input  logic [NUM_WRITE*BIT_WIDTH-1:0] wdata,
  input  logic [DEPTH*BIT_WIDTH-1:0]     mem_flat,
  output logic [BIT_WIDTH-1:0]           rdata
);

  logic [BIT_WIDTH-1:0] mem_word;
  logic [BIT_WIDTH-1:0] byp_word;
  logic                 hit;
  rd_src_e              src;

  // Only addresses below DEPTH can match, which doubles as the range check.
  always_comb begin
    mem_word = '0;
    hit      = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) begin
        mem_word = mem_flat[i*BIT_WIDTH +: BIT_WIDTH];
        hit      = 1'b1;
      end
    end
  end

  always_comb begin
    src      = RD_ZERO;
    byp_word = '0;
    if (load && hit) begin
      src = RD_MEM;
      if (BYPASS != 0) begin
        // Later write ports overwrite earlier matches, mirroring collision precedence.
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (save[w] && (waddr[w*ADDR_W +: ADDR_W] == raddr)) begin
            src      = clear ? RD_ZERO : RD_BYPASS;
            byp_word = wdata[w*BIT_WIDTH +: BIT_WIDTH];
          end
        end
      end
    end
    if (rst) src = RD_ZERO;
  end

  always_comb begin
    rdata = '0;
    case (src)
      RD_MEM:    rdata = mem_word;
      RD_BYPASS: rdata = byp_word;
      default:   rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/tc_register_file.sv
// tc_register_file: DEPTH x BIT_WIDTH register bank with NUM_WRITE write and NUM_READ gated read ports.
// Rev 1.0
`default_nettype none

module tc_register_file
  import tc_register_file_pkg::*;
#(
  parameter int UUID      = 0,
  parameter     NAME      = "",
  parameter int BIT_WIDTH = 8,
  parameter int DEPTH     = 8,
  parameter int NUM_READ  = 2,
  parameter int NUM_WRITE = 1,
  parameter int BYPASS    = 0,
  localparam int ADDR_W   = addr_width(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [NUM_WRITE-1:0]           save,
  input  logic [NUM_WRITE*ADDR_W-1:0]    waddr,
  input  logic [NUM_WRITE*BIT_WIDTH-1:0] in,
  input  logic [NUM_READ-1:0]            load,
  input  logic [NUM_READ*ADDR_W-1:0]     raddr,
  output logic [NUM_READ*BIT_WIDTH-1:0]  out
);

  if (UUID < 0) begin : g_bad_uuid
    $error("tc_register_file: UUID must be non-negative");
  end
  if ($bits(NAME) > 4096) begin : g_bad_name
    $error("tc_register_file: NAME too long");
  end
  if (BIT_WIDTH < 1 || DEPTH < 2) begin : g_bad_size
    $error("tc_register_file: BIT_WIDTH >= 1 and DEPTH >= 2 required");
  end
  if (NUM_READ < 1 || NUM_READ > 4 || NUM_WRITE < 1 || NUM_WRITE > 2) begin : g_bad_ports
    $error("tc_register_file: NUM_READ 1..4, NUM_WRITE 1..2");
  end

  logic [BIT_WIDTH-1:0]       mem [DEPTH];
  logic [DEPTH*BIT_WIDTH-1:0] mem_flat;

  // Per-entry decode keeps out-of-range addresses from touching storage;
  // iterating write ports upward lets the highest port win a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int w = 0; w < NUM_WRITE; w++) begin
          if (save[w] && (waddr[w*ADDR_W +: ADDR_W] == ADDR_W'(i))) begin
            mem[i] <= in[w*BIT_WIDTH +: BIT_WIDTH];
          end
        end
      end
    end
  end

  for (genvar d = 0; d < DEPTH; d++) begin : g_flat
    assign mem_flat[d*BIT_WIDTH +: BIT_WIDTH] = mem[d];
  end

  for (genvar r = 0; r < NUM_READ; r++) begin : g_rdport
    tc_register_file_rdport #(
      .BIT_WIDTH (BIT_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W),
      .NUM_WRITE (NUM_WRITE),
      .BYPASS    (BYPASS)
    ) u_rdport (
      .rst      (rst),
      .clear    (clear),
      .load     (load[r]),
      .raddr    (raddr[r*ADDR_W +: ADDR_W]),
      .save     (save),
      .waddr    (waddr),
      .wdata    (in),
      .mem_flat (mem_flat),
      .rdata    (out[r*BIT_WIDTH +: BIT_WIDTH])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_tc_register_file.sv
// tb_tc_register_file: two configurations (DEPTH 8 no bypass, DEPTH 6 with bypass) against a bench model.
`default_nettype none

module tb_tc_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [1:0]  save;
  logic [5:0]  waddr;
  logic [15:0] in;
  logic [1:0]  load;
  logic [5:0]  raddr;
  logic [15:0] out_a;
  logic [15:0] out_b;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mm [2][8];

  always #5 clk = ~clk;

  tc_register_file #(.UUID(1), .NAME("rf_a"), .BIT_WIDTH(8), .DEPTH(8), .NUM_READ(2),
                     .NUM_WRITE(2), .BYPASS(0)) dut_a (
    .clk(clk), .rst(rst), .clear(clear), .save(save), .waddr(waddr), .in(in),
    .load(load), .raddr(raddr), .out(out_a));

  tc_register_file #(.UUID(2), .NAME("rf_b"), .BIT_WIDTH(8), .DEPTH(6), .NUM_READ(2),
                     .NUM_WRITE(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .save(save), .waddr(waddr), .in(in),
    .load(load), .raddr(raddr), .out(out_b));

  function automatic int depth_of(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  // Bank state: reset/clear wipe, else each valid save stores (port 1 applied last).
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst || clear) begin
        for (int a = 0; a < 8; a++) mm[k][a] = 8'h00;
      end else begin
        for (int w = 0; w < 2; w++) begin
          if (save[w] && int'(waddr[w*3 +: 3]) < depth_of(k)) mm[k][waddr[w*3 +: 3]] = in[w*8 +: 8];
        end
      end
    end
  end

  function automatic logic [7:0] exp_out(input int k, input int r);
    int         a;
    logic [7:0] v;
    if (rst || !load[r]) return 8'h00;
    a = int'(raddr[r*3 +: 3]);
    if (a >= depth_of(k)) return 8'h00;
    v = mm[k][a];
    if (k == 1) begin
      for (int w = 0; w < 2; w++)
        if (save[w] && int'(waddr[w*3 +: 3]) == a) v = clear ? 8'h00 : in[w*8 +: 8];
    end
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int r = 0; r < 2; r++) begin
      check($sformatf("cmp a out%0d", r), out_a[r*8 +: 8], exp_out(0, r));
      check($sformatf("cmp b out%0d", r), out_b[r*8 +: 8], exp_out(1, r));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input logic [2:0] a, input logic [7:0] d);
    save = 2'b00;
    save[p] = 1'b1;
    waddr[p*3 +: 3] = a;
    in[p*8 +: 8] = d;
    tick();
    save = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; clear = 1'b0; save = 2'b01; waddr = 6'd0; in = 16'h00FF;
    load = 2'b11; raddr = 6'd0;
    repeat (3) tick();
    check("reset out_a", out_a[7:0], 8'h00);
    rst = 1'b0; save = 2'b00;
    #1 check("post-reset save ignored", out_a[7:0], 8'h00);

    // 1: fill with A5, then async reset pulse
    for (int a = 0; a < 8; a++) wr(0, 3'(a), 8'hA5);
    load = 2'b11; raddr = {3'd7, 3'd3};
    #1;
    check("fill a r0", out_a[7:0], 8'hA5);
    check("fill a r1", out_a[15:8], 8'hA5);
    check("fill b r0", out_b[7:0], 8'hA5);
    check("fill b r1 oob", out_b[15:8], 8'h00);
    save = 2'b01; waddr = {3'd0, 3'd3}; in = 16'h003C;
    #1 rst = 1'b1;
    #1;
    check("rst async a r0", out_a[7:0], 8'h00);
    check("rst async a r1", out_a[15:8], 8'h00);
    check("rst async b r0", out_b[7:0], 8'h00);
    tick();
    rst = 1'b0; save = 2'b00;
    #1 check("save during rst", out_a[7:0], 8'h00);
    tick();

    // 2: write/read and load gating
    load = 2'b00;
    wr(0, 3'd3, 8'h5C);
    load = 2'b01; raddr = {3'd0, 3'd3};
    #1 check("wr rd a", out_a[7:0], 8'h5C);
    load = 2'b00;
    #1 check("unloaded a", out_a[7:0], 8'h00);
    tick();

    // 3: dual-port read
    wr(0, 3'd2, 8'h11);
    wr(1, 3'd5, 8'h22);
    load = 2'b11; raddr = {3'd5, 3'd2};
    #1;
    check("dual a r0", out_a[7:0], 8'h11);
    check("dual a r1", out_a[15:8], 8'h22);
    check("dual b r1", out_b[15:8], 8'h22);
    tick();

    // 4: collision, then collision with clear
    save = 2'b11; waddr = {3'd1, 3'd1}; in = 16'hF00F;
    tick();
    save = 2'b00; load = 2'b11; raddr = {3'd2, 3'd1};
    #1 check("collision a", out_a[7:0], 8'hF0);
    save = 2'b11; clear = 1'b1;
    tick();
    save = 2'b00; clear = 1'b0;
    #1;
    check("clear a e1", out_a[7:0], 8'h00);
    check("clear a e2", out_a[15:8], 8'h00);

    // 5: bypass behaviour
    wr(0, 3'd4, 8'h33);
    save = 2'b01; waddr = {3'd0, 3'd4}; in = 16'h0077; load = 2'b01; raddr = {3'd0, 3'd4};
    #1;
    check("no-bypass old", out_a[7:0], 8'h33);
    check("bypass new", out_b[7:0], 8'h77);
    tick();
    save = 2'b00;
    #1 check("no-bypass after edge", out_a[7:0], 8'h77);
    save = 2'b11; waddr = {3'd4, 3'd4}; in = 16'hBBAA;
    #1 check("bypass collision", out_b[7:0], 8'hBB);
    clear = 1'b1;
    #1;
    check("bypass clear b", out_b[7:0], 8'h00);
    check("bypass clear a old", out_a[7:0], 8'h77);
    tick();
    save = 2'b00; clear = 1'b0;

    // 6: bounds on DEPTH 6
    for (int a = 0; a < 6; a++) wr(a % 2, 3'(a), 8'(8'h40 + a));
    wr(0, 3'd7, 8'h99);
    wr(1, 3'd6, 8'h66);
    load = 2'b11; raddr = {3'd7, 3'd6};
    #1;
    check("oob rd b 6", out_b[7:0], 8'h00);
    check("oob rd b 7", out_b[15:8], 8'h00);
    check("in range a 6", out_a[7:0], 8'h66);
    check("in range a 7", out_a[15:8], 8'h99);
    for (int a = 0; a < 6; a++) begin
      raddr = {3'd0, 3'(a)};
      tick();
    end
    raddr = {3'd0, 3'd5};
    #1 check("oob write no effect b5", out_b[7:0], 8'h45);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
